// File: rtl/tx_update_packer.sv
// tx_update_packer: drains per-worker {key,val} FIFOs round-robin into header+payload packets
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   tx_fifo_q          per-worker FIFO read data {key,val}, valid the cycle after a pop
//   tx_fifo_empty      per-worker FIFO empty
//   tx_fifo_rdreq      per-worker registered one-cycle pop
//   num_workers        runtime worker count, clamped to 1..MAX_NUM_WORKERS
//   pkt_data/valid/ready/sop/eop/dest  packet stream to the framer (header word then payload)
module tx_update_packer #(
  parameter int MAX_NUM_WORKERS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BATCH = 16
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [MAX_NUM_WORKERS-1:0][2*DATA_WIDTH-1:0]  tx_fifo_q,
  input  logic [MAX_NUM_WORKERS-1:0]                    tx_fifo_empty,
  output logic [MAX_NUM_WORKERS-1:0]                    tx_fifo_rdreq,
  input  logic [$clog2(MAX_NUM_WORKERS):0]              num_workers,
  output logic [2*DATA_WIDTH-1:0]                       pkt_data,
  output logic                                          pkt_valid,
  input  logic                                          pkt_ready,
  output logic                                          pkt_sop,
  output logic                                          pkt_eop,
  output logic [$clog2(MAX_NUM_WORKERS)-1:0]            pkt_dest
);
  localparam int WW = $clog2(MAX_NUM_WORKERS);
  localparam int CW = $clog2(MAX_BATCH + 1);
  localparam int IW = $clog2(MAX_BATCH);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [WW:0] NMAX = (WW+1)'(MAX_NUM_WORKERS);
  typedef enum logic [2:0] {SCAN, FETCH, WAIT, CAPTURE, HDR, PAYLOAD} state_e;
  state_e state_q, state_d;
  logic [WW-1:0] cur_q, cur_d, dest_q, dest_d;
  logic [WW:0] nw, nw_q, nw_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0] seq_q, seq_d;
  logic [PW-1:0] data_q, data_d;
  logic valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [MAX_NUM_WORKERS-1:0] rd_q, rd_d;
  logic [PW-1:0] buf_q [MAX_BATCH];
  function automatic logic [WW-1:0] rr(input logic [WW-1:0] c, input logic [WW:0] n);
    // also folds an out-of-range cur (after num_workers shrank) back to worker 0
    return ({1'b0, c} >= n - 1'b1) ? '0 : c + 1'b1;
  endfunction
  assign nw = (num_workers == '0) ? (WW+1)'(1) : (num_workers > NMAX) ? NMAX : num_workers;
  assign cnt_inc = cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    nw_d = nw_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    seq_d = seq_q;
    data_d = data_q;
    valid_d = valid_q;
    sop_d = sop_q;
    eop_d = eop_q;
    dest_d = dest_q;
    rd_d = '0;
    unique case (state_q)
      SCAN: begin
        nw_d = nw;
        if ({1'b0, cur_q} < nw && !tx_fifo_empty[cur_q]) begin
          state_d = FETCH;
          rd_d[cur_q] = 1'b1;
        end else begin
          cur_d = rr(cur_q, nw);
        end
      end
      FETCH: state_d = WAIT;
      WAIT: state_d = CAPTURE;
      CAPTURE: begin
        cnt_d = cnt_inc;
        // empty here already reflects the pop issued in FETCH
        if (cnt_inc == CW'(MAX_BATCH) || tx_fifo_empty[cur_q]) begin
          state_d = HDR;
          valid_d = 1'b1;
          sop_d = 1'b1;
          eop_d = 1'b0;
          dest_d = cur_q;
          data_d = PW'({8'hCA, 8'(cur_q), 16'(cnt_inc), seq_q});
        end else begin
          state_d = FETCH;
          rd_d[cur_q] = 1'b1;
        end
      end
      HDR: if (pkt_ready) begin
        state_d = PAYLOAD;
        idx_d = '0;
        sop_d = 1'b0;
        eop_d = (cnt_q == CW'(1));
        data_d = buf_q[0];
      end
      PAYLOAD: if (pkt_ready) begin
        if (eop_q) begin
          state_d = SCAN;
          seq_d = seq_q + 1'b1;
          cnt_d = '0;
          cur_d = rr(cur_q, nw_q);
          valid_d = 1'b0;
          eop_d = 1'b0;
          data_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
          eop_d = (CW'(idx_q) + CW'(2) == cnt_q);
          data_d = buf_q[idx_q + 1'b1];
        end
      end
      default: state_d = SCAN;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCAN;
      cur_q <= '0;
      nw_q <= (WW+1)'(1);
      cnt_q <= '0;
      idx_q <= '0;
      seq_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      dest_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      nw_q <= nw_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seq_q <= seq_d;
      data_q <= data_d;
      valid_q <= valid_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      dest_q <= dest_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE) buf_q[cnt_q[IW-1:0]] <= tx_fifo_q[cur_q];
  end
  assign tx_fifo_rdreq = rd_q;
  assign pkt_data = data_q;
  assign pkt_valid = valid_q;
  assign pkt_sop = sop_q;
  assign pkt_eop = eop_q;
  assign pkt_dest = dest_q;
endmodule

// File: tb/tb_tx_update_packer.sv
// tb_tx_update_packer: scoreboard bench for tx_update_packer with a legacy-mode FIFO model
module tb_tx_update_packer;
  localparam int N = 4;
  typedef struct packed {logic sop; logic eop; logic [1:0] dest; logic [63:0] data;} word_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0][63:0] tx_fifo_q;
  logic [N-1:0] tx_fifo_empty, tx_fifo_rdreq;
  logic [2:0] num_workers;
  logic [63:0] pkt_data;
  logic pkt_valid, pkt_ready, pkt_sop, pkt_eop;
  logic [1:0] pkt_dest;
  word_t sb[$];
  logic [63:0] fq[N][$];
  logic [63:0] mq[N][$];
  int pops[N];
  int n_chk = 0, n_pass = 0, pay_idx = 0;
  logic [31:0] exp_seq = '0;
  tx_update_packer #(.MAX_NUM_WORKERS(4), .DATA_WIDTH(32), .MAX_BATCH(16)) dut (
    .clk(clk), .reset_n(reset_n), .tx_fifo_q(tx_fifo_q), .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_rdreq(tx_fifo_rdreq), .num_workers(num_workers), .pkt_data(pkt_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_dest(pkt_dest)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic push(input int w, input logic [63:0] d);
    fq[w].push_back(d);
    mq[w].push_back(d);
    tx_fifo_empty[w] = 1'b0;
  endtask
  task automatic expect_pkt(input int w, input int n);
    sb.push_back({1'b1, 1'b0, 2'(w), 8'hCA, 8'(w), 16'(n), exp_seq});
    for (int i = 0; i < n; i++) sb.push_back({1'b0, i == n - 1, 2'(w), mq[w].pop_front()});
    exp_seq++;
  endtask
  task automatic tick();
    logic [N-1:0] rd;
    word_t e;
    rd = tx_fifo_rdreq;
    if (rd != '0) begin
      chk("rdreq_onehot", 64'($countones(rd)), 64'd1);
      chk("rdreq_while_valid", 64'(pkt_valid), 64'd0);
    end
    if (pkt_valid && pkt_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pkt_data", pkt_data, e.data);
        chk("pkt_flags", 64'({pkt_sop, pkt_eop, pkt_dest}), 64'({e.sop, e.eop, e.dest}));
      end
      pay_idx = pkt_sop ? 0 : pay_idx + 1;
    end
    @(posedge clk);
    #1;
    for (int w = 0; w < N; w++) begin
      if (rd[w]) begin
        pops[w]++;
        chk("pop_nonempty", 64'(fq[w].size() != 0), 64'd1);
        if (fq[w].size() != 0) tx_fifo_q[w] = fq[w].pop_front();
      end
      tx_fifo_empty[w] = (fq[w].size() == 0);
    end
  endtask
  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk("drained", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    logic [63:0] hold;
    logic seen3, anyv, he;
    int t;
    tx_fifo_q = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    tx_fifo_empty = '1;
    num_workers = 3'd4;
    pkt_ready = 1'b1;
    for (int w = 0; w < N; w++) pops[w] = 0;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(pkt_valid), 64'd0);
    chk("rst_sop", 64'(pkt_sop), 64'd0);
    chk("rst_eop", 64'(pkt_eop), 64'd0);
    chk("rst_data", pkt_data, 64'd0);
    chk("rst_dest", 64'(pkt_dest), 64'd0);
    chk("rst_rdreq", 64'(tx_fifo_rdreq), 64'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_pops", 64'(pops[0] + pops[1] + pops[2] + pops[3]), 64'd0);
    // three pairs in worker 1
    push(1, 64'h00000011_3F800000);
    push(1, 64'h00000021_40000000);
    push(1, 64'h00000031_40400000);
    expect_pkt(1, 3);
    drain(200);
    chk("w1_pops", 64'(pops[1]), 64'd3);
    chk("other_pops", 64'(pops[0] + pops[2] + pops[3]), 64'd0);
    // 20 pairs in worker 0 split into 16 + 4
    for (int i = 0; i < 20; i++) push(0, {32'h1000 + 32'(i), 32'(i * 7 + 1)});
    expect_pkt(0, 16);
    expect_pkt(0, 4);
    drain(600);
    chk("w0_pops", 64'(pops[0]), 64'd20);
    // backpressure at payload idx 2
    for (int i = 0; i < 5; i++) push(2, {32'h2000 + 32'(i), 32'hA5A5_0000 | 32'(i)});
    expect_pkt(2, 5);
    t = 0;
    while (!(pkt_valid && !pkt_sop && pay_idx == 2) && t < 200) begin tick(); t++; end
    chk("reach_idx2", 64'(t < 200), 64'd1);
    pkt_ready = 1'b0;
    hold = pkt_data;
    he = pkt_eop;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", pkt_data, hold);
      chk("stall_valid", 64'(pkt_valid), 64'd1);
      chk("stall_eop", 64'(pkt_eop), 64'(he));
    end
    pkt_ready = 1'b1;
    tick();
    chk("resume_idx3", pkt_data, (sb.size() != 0) ? sb[0].data : 64'hX);
    drain(100);
    // workers beyond num_workers are never read
    num_workers = 3'd2;
    push(3, 64'h00000033_11111111);
    push(3, 64'h00000043_22222222);
    seen3 = 1'b0;
    anyv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen3 |= tx_fifo_rdreq[3];
      anyv |= pkt_valid;
      tick();
    end
    chk("w3_unread", 64'(seen3), 64'd0);
    chk("w3_no_pkt", 64'(anyv), 64'd0);
    num_workers = 3'd4;
    expect_pkt(3, 2);
    drain(200);
    // num_workers=0 behaves as 1
    num_workers = 3'd0;
    push(1, 64'h00000051_33333333);
    push(0, 64'h00000050_44444444);
    expect_pkt(0, 1);
    drain(200);
    for (int i = 0; i < 20; i++) tick();
    chk("nw0_w1_unread", 64'(fq[1].size()), 64'd1);
    num_workers = 3'd4;
    expect_pkt(1, 1);
    drain(200);
    // asynchronous reset mid-payload drops the packet
    for (int i = 0; i < 6; i++) push(0, {32'h6000 + 32'(i), 32'(i)});
    expect_pkt(0, 6);
    t = 0;
    while (!(pkt_valid && !pkt_sop && pay_idx == 2) && t < 200) begin tick(); t++; end
    chk("reach_mid", 64'(t < 200), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(pkt_valid), 64'd0);
    chk("arst_sop_eop", 64'({pkt_sop, pkt_eop}), 64'd0);
    chk("arst_rdreq", 64'(tx_fifo_rdreq), 64'd0);
    sb.delete();
    for (int w = 0; w < N; w++) begin fq[w].delete(); mq[w].delete(); end
    tx_fifo_empty = '1;
    exp_seq = '0;
    pay_idx = 0;
    @(posedge clk);
    #1;
    // after release cur=0, so worker 0 is served before worker 1, then back to 0
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) push(0, {32'h7000 + 32'(i), 32'(i * 3)});
    push(1, 64'h00000071_55555555);
    push(1, 64'h00000081_66666666);
    expect_pkt(0, 16);
    expect_pkt(1, 2);
    expect_pkt(0, 4);
    drain(800);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
